sha256_round_engine: RTL

//  SHA-256 compression core, directly downstream of the message-schedule (W) expander.
//  - Consumes one 32-bit schedule word W[t] per round over a valid/ready handshake.
//  - Runs ROUNDS compression rounds on working variables a..h.
//  - Adds the result to the chaining hash and presents a 256-bit digest.
//  - Chaining across message blocks: the caller feeds digest back as hash_in.

---
 rtl/sha256_round_engine.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/sha256_round_engine.sv
// sha256_round_engine
// SHA-256 compression core. Takes one schedule word W[t] per round over a
// w_valid/w_ready handshake, runs ROUNDS rounds on a..h, then adds the
// result to the chaining hash and pulses digest_valid for one cycle.
// Optional build macro: SHA256_W_INDEX_CHECK_EN adds w_index / idx_err, which
// flag any accepted word whose index differs from the round counter.
module sha256_round_engine #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = $clog2(ROUNDS)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [255:0]       hash_in,
    input  logic               w_valid,
    input  logic [31:0]        w_word,
`ifdef SHA256_W_INDEX_CHECK_EN
    input  logic [IDX_W-1:0]   w_index,
    output logic               idx_err,
`endif
    output logic               w_ready,
    output logic               busy,
    output logic [255:0]       digest,
    output logic               digest_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_ROUND = IDX_W'(ROUNDS - 1);

    localparam logic [31:0] K_TABLE [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] round_cnt;
    logic [31:0]      hash_q [8];
    logic [31:0]      work_q [8];
    logic [31:0]      t1;
    logic [31:0]      t2;
    logic             accept;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] choose(input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] majority(input logic [31:0] x, input logic [31:0] y,
                                             input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    assign accept = w_valid && w_ready;

    // State register; reset abandons any block in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only matters in IDLE, FINAL lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ROUND;
            ROUND:   if (accept && (round_cnt == LAST_ROUND)) state_d = FINAL;
            FINAL:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        w_ready = 1'b0;
        busy    = 1'b0;
        case (state_q)
            ROUND: begin
                w_ready = 1'b1;
                busy    = 1'b1;
            end
            FINAL:   busy = 1'b1;
            default: ;
        endcase
    end

    // One compression round's temporaries for the current a..h and W[t].
    always_comb begin
        t1 = work_q[7] + big_sigma1(work_q[4]) + choose(work_q[4], work_q[5], work_q[6])
             + K_TABLE[round_cnt] + w_word;
        t2 = big_sigma0(work_q[0]) + majority(work_q[0], work_q[1], work_q[2]);
    end

    // Datapath: load on start, shift a..h per accepted word, fold into digest in FINAL.
    always_ff @(posedge clock) begin
        if (!reset) begin
            round_cnt    <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hash_q[i] <= '0;
                work_q[i] <= '0;
            end
        end else begin
            digest_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        round_cnt <= '0;
                        for (int i = 0; i < 8; i++) begin
                            hash_q[i] <= hash_in[255-32*i -: 32];
                            work_q[i] <= hash_in[255-32*i -: 32];
                        end
                    end
                end
                ROUND: begin
                    if (accept) begin
                        work_q[0] <= t1 + t2;
                        work_q[1] <= work_q[0];
                        work_q[2] <= work_q[1];
                        work_q[3] <= work_q[2];
                        work_q[4] <= work_q[3] + t1;
                        work_q[5] <= work_q[4];
                        work_q[6] <= work_q[5];
                        work_q[7] <= work_q[6];
                        if (round_cnt != LAST_ROUND) begin
                            round_cnt <= round_cnt + IDX_W'(1);
                        end
                    end
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        digest[255-32*i -: 32] <= hash_q[i] + work_q[i];
                    end
                    digest_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SHA256_W_INDEX_CHECK_EN
    // Sticky flag for an accepted word whose index is not the current round.
    always_ff @(posedge clock) begin
        if (!reset) begin
            idx_err <= 1'b0;
        end else if ((state_q == IDLE) && start) begin
            idx_err <= 1'b0;
        end else if (accept && (w_index != round_cnt)) begin
            idx_err <= 1'b1;
        end
    end
`endif

endmodule
